store_drain_buffer: RTL and testbench

// - Responder side of the SQ->D$ store handshake: accepts retired stores (addr/data/size), acks with store_accepted.
// - Buffers accepted stores in a FIFO write buffer and drains them to main memory through the BUS_STORE command port.
// - Arbitrates with the load-miss port; reports load/buffer address conflicts so loads never bypass a pending store.

---
 rtl/store_drain_buffer_pkg.sv | 46 ++++
 rtl/store_drain_buffer_if.sv | 58 +++++
 rtl/store_drain_buffer_wb_fifo.sv | 91 +++++++++
 rtl/store_drain_buffer.sv | 168 ++++++++++++++++
 tb/tb_store_drain_buffer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_drain_buffer_pkg.sv
// Shared types for the store drain buffer: bus command / size encodings,
// write-buffer entry layout, drain FSM states and small lane helpers.
package store_drain_buffer_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_e;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } mem_size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } store_drain_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        mem_size_e   mem_size;
    } wb_entry_t;

    // Move lane-aligned store data down to bit 0 (zero-extended).
    function automatic logic [31:0] right_align(input logic [31:0] data, input logic [1:0] lane);
        return data >> {lane, 3'b000};
    endfunction

    // Byte enables of a lane-aligned access within the 32-bit word.
    function automatic logic [3:0] byte_enable(input logic [1:0] lane, input mem_size_e size);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << lane;
            HALF:    be = 4'b0011 << {lane[1], 1'b0};
            WORD:    be = 4'b1111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/store_drain_buffer_if.sv
// Store-queue / load-port / memory-bus signal bundle of the store drain buffer.
// DCACHE_WRITE_THROUGH_EN selects write-through update signals; otherwise
// invalidate signals are carried instead.
interface store_drain_buffer_if;
    import store_drain_buffer_pkg::*;

    logic         store_en;
    logic [31:0]  store_addr;
    logic [31:0]  store_data;
    logic         is_32_bit;
    logic         is_16_bit;
    logic         store_accepted;
    logic         load_mem_req;
    logic         store_mem_hold;
    logic         load_query_valid;
    logic [31:0]  load_query_addr;
    logic         load_conflict;
    bus_command_e proc2mem_command;
    logic [31:0]  proc2mem_addr;
    logic [63:0]  proc2mem_data;
    mem_size_e    proc2mem_size;
    logic [3:0]   mem2proc_response;
    logic         wb_empty;
`ifdef DCACHE_WRITE_THROUGH_EN
    logic         dcache_wr_en;
    logic [31:0]  dcache_wr_addr;
    logic [31:0]  dcache_wr_data;
    logic [3:0]   dcache_wr_be;
`else
    logic         dcache_inval;
    logic [31:0]  dcache_inval_addr;
`endif

    modport master (
        output store_en, store_addr, store_data, is_32_bit, is_16_bit,
        output load_mem_req, load_query_valid, load_query_addr, mem2proc_response,
        input  store_accepted, store_mem_hold, load_conflict,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size, wb_empty
`ifdef DCACHE_WRITE_THROUGH_EN
        , input dcache_wr_en, dcache_wr_addr, dcache_wr_data, dcache_wr_be
`else
        , input dcache_inval, dcache_inval_addr
`endif
    );

    modport slave (
        input  store_en, store_addr, store_data, is_32_bit, is_16_bit,
        input  load_mem_req, load_query_valid, load_query_addr, mem2proc_response,
        output store_accepted, store_mem_hold, load_conflict,
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size, wb_empty
`ifdef DCACHE_WRITE_THROUGH_EN
        , output dcache_wr_en, dcache_wr_addr, dcache_wr_data, dcache_wr_be
`else
        , output dcache_inval, dcache_inval_addr
`endif
    );

endinterface

// File: rtl/store_drain_buffer_wb_fifo.sv
// wb_fifo: circular write buffer of store entries. Pointers carry an extra
// wrap bit to tell full from empty; push and pop may coincide at any
// occupancy, including full. All entries are exposed for address compare.
module wb_fifo
    import store_drain_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_i,
    input  wb_entry_t                     push_entry_i,
    input  logic                          pop_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output wb_entry_t                     head_o,
    output wb_entry_t [DEPTH-1:0]         entries_o,
    output logic [DEPTH-1:0]              valid_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_idx_s, rd_idx_s;
    logic                  do_push_s, do_pop_s;
    logic                  full_q, full_d, empty_q, empty_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    wb_entry_t [DEPTH-1:0] mem_q;

    // Next pointers, per-slot valid bits and the full/empty flags they imply.
    always_comb begin
        wr_idx_s  = wr_ptr_q[PW-1:0];
        rd_idx_s  = rd_ptr_q[PW-1:0];
        do_pop_s  = pop_i && !empty_q;
        do_push_s = push_i && (!full_q || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        valid_d   = valid_q;
        // Clear before set: at full both indices coincide and the slot stays valid.
        if (do_pop_s) begin
            rd_ptr_d          = rd_ptr_q + (PW+1)'(1);
            valid_d[rd_idx_s] = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            wr_ptr_d          = wr_ptr_q + (PW+1)'(1);
            valid_d[wr_idx_s] = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[PW] != rd_ptr_d[PW]) && (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
    end

    // Pointer and occupancy-flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage; cleared on reset so an idle head reads as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '0;
        end else if (do_push_s) begin
            mem_q[wr_idx_s] <= push_entry_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign head_o    = mem_q[rd_idx_s];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/store_drain_buffer.sv
// store_drain_buffer: accepts retired stores from the store queue, holds them
// in a FIFO write buffer and drains them to memory with BUS_STORE, sharing the
// bus with the load-miss port under a starvation limit. Loads overlapping a
// buffered store (8-byte granularity) are flagged so they retry.
// Optional feature macro DCACHE_WRITE_THROUGH_EN: when defined, each accepted
// store writes through to the dcache; otherwise the block is invalidated.
module store_drain_buffer
    import store_drain_buffer_pkg::*;
#(
    parameter int unsigned WB_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    store_drain_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(WB_DEPTH);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    store_drain_state_e       state_q, state_d;
    logic [CW-1:0]            starve_q, starve_d;
    logic                     push_s, pop_s, issue_s, granted_s, hit_s;
    logic                     full_s, empty_s;
    logic [PW:0]              count_s;
    mem_size_e                size_s;
    wb_entry_t                push_entry_s, head_s;
    wb_entry_t [WB_DEPTH-1:0] entries_s;
    logic [WB_DEPTH-1:0]      valid_s;

    wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .count_o      (count_s),
        .head_o       (head_s),
        .entries_o    (entries_s),
        .valid_o      (valid_s)
    );

    // Accept decision (registered full flag only) and the entry to be buffered.
    always_comb begin
        push_s = bus.store_en && !full_s;
        if (bus.is_32_bit) begin
            size_s = WORD;
        end else if (bus.is_16_bit) begin
            size_s = HALF;
        end else begin
            size_s = BYTE;
        end
        push_entry_s.addr     = bus.store_addr;
        push_entry_s.data     = right_align(bus.store_data, bus.store_addr[1:0]);
        push_entry_s.mem_size = size_s;
    end

    // Drain FSM: next state, bus grant, pop and starvation counter.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        pop_s     = 1'b0;
        issue_s   = 1'b0;
        granted_s = !bus.load_mem_req || (starve_q == CW'(STARVE_LIMIT));
        case (state_q)
            IDLE: begin
                // Leaving on the accept itself gives a one-cycle store-to-bus latency.
                if (!empty_s || push_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (empty_s) begin
                    state_d = push_s ? ISSUE : IDLE;
                end else if (granted_s) begin
                    issue_s = 1'b1;
                    if (bus.mem2proc_response != 4'h0) begin
                        pop_s    = 1'b1;
                        starve_d = '0;
                        if ((count_s == (PW+1)'(1)) && !push_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = ISSUE;
                        end
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = ISSUE;
                    if (starve_q != CW'(STARVE_LIMIT)) begin
                        starve_d = starve_q + CW'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drain FSM state and starvation counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Load address conflict against every buffered entry and the one arriving now.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < int'(WB_DEPTH); i++) begin
            if (valid_s[i] && (entries_s[i].addr[31:3] == bus.load_query_addr[31:3])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        if (push_s && (bus.store_addr[31:3] == bus.load_query_addr[31:3])) begin
            hit_s = 1'b1;
        end else begin
            hit_s = hit_s;
        end
        bus.load_conflict = bus.load_query_valid && hit_s;
    end

    // Handshake, memory bus drive and status outputs.
    always_comb begin
        bus.store_accepted   = push_s;
        bus.store_mem_hold   = issue_s;
        bus.proc2mem_command = issue_s ? BUS_STORE : BUS_NONE;
        if (issue_s) begin
            bus.proc2mem_addr = head_s.addr;
            bus.proc2mem_data = {32'h0000_0000, head_s.data};
            bus.proc2mem_size = head_s.mem_size;
        end else begin
            bus.proc2mem_addr = 32'h0000_0000;
            bus.proc2mem_data = 64'h0000_0000_0000_0000;
            bus.proc2mem_size = BYTE;
        end
        bus.wb_empty = empty_s && (state_q == IDLE);
    end

`ifdef DCACHE_WRITE_THROUGH_EN
    // Write-through update of the dcache on every accepted store.
    always_comb begin
        bus.dcache_wr_en   = push_s;
        bus.dcache_wr_addr = bus.store_addr;
        bus.dcache_wr_data = bus.store_data;
        bus.dcache_wr_be   = byte_enable(bus.store_addr[1:0], size_s);
    end
`else
    // Invalidate the 8-byte dcache block touched by every accepted store.
    always_comb begin
        bus.dcache_inval      = push_s;
        bus.dcache_inval_addr = {bus.store_addr[31:3], 3'b000};
    end
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench for store_drain_buffer: directed scenarios followed by
// randomized traffic, every cycle compared against a queue-based reference.
module tb_store_drain_buffer;
    import store_drain_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } ref_entry_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    store_drain_buffer_if sif();

    store_drain_buffer #(.WB_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (rst),
        .bus   (sif)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_pass   = 0;
    ref_entry_t mq[$];
    int         starve = 0;
    logic       m_ack, m_issue, m_pop, m_nonempty, m_granted;
    ref_entry_t m_new;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: predicts this cycle's outputs from the queue and inputs.
    task automatic model_check();
        logic       hit;
        logic [1:0] lane;
        logic [3:0] be;
        lane       = sif.store_addr[1:0];
        m_nonempty = (mq.size() != 0);
        m_ack      = sif.store_en && (mq.size() < DEPTH);
        m_granted  = !sif.load_mem_req || (starve == LIMIT);
        m_issue    = m_nonempty && m_granted;
        m_pop      = m_issue && (sif.mem2proc_response != 4'h0);
        m_new.addr = sif.store_addr;
        m_new.data = sif.store_data >> (8 * lane);
        m_new.size = sif.is_32_bit ? 2'd2 : (sif.is_16_bit ? 2'd1 : 2'd0);
        hit = 1'b0;
        foreach (mq[i]) if (mq[i].addr[31:3] == sif.load_query_addr[31:3]) hit = 1'b1;
        if (m_ack && (sif.store_addr[31:3] == sif.load_query_addr[31:3])) hit = 1'b1;
        case (m_new.size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = 4'b0011 << {lane[1], 1'b0};
            default: be = 4'b1111;
        endcase
        if (!rst) begin
            check("ack", sif.store_accepted, m_ack);
            check("cmd", sif.proc2mem_command, m_issue ? BUS_STORE : BUS_NONE);
            check("hold", sif.store_mem_hold, m_issue);
            check("wb_empty", sif.wb_empty, !m_nonempty);
            check("conflict", sif.load_conflict, sif.load_query_valid && hit);
            if (m_issue) begin
                check("bus_addr", sif.proc2mem_addr, mq[0].addr);
                check("bus_data", sif.proc2mem_data, {32'h0, mq[0].data});
                check("bus_size", sif.proc2mem_size, mq[0].size);
            end
`ifdef DCACHE_WRITE_THROUGH_EN
            check("dc_wr_en", sif.dcache_wr_en, m_ack);
            if (m_ack) begin
                check("dc_wr_addr", sif.dcache_wr_addr, sif.store_addr);
                check("dc_wr_data", sif.dcache_wr_data, sif.store_data);
                check("dc_wr_be", sif.dcache_wr_be, be);
            end
`else
            check("dc_inval", sif.dcache_inval, m_ack);
            if (m_ack) check("dc_inval_addr", sif.dcache_inval_addr, {sif.store_addr[31:3], 3'b000});
`endif
        end
    endtask

    task automatic settle();
        @(negedge clock);
        model_check();
    endtask

    // Clock edge, then apply the model's state update.
    task automatic advance();
        ref_entry_t e;
        @(posedge clock);
        #1;
        if (rst) begin
            mq.delete();
            starve = 0;
        end else begin
            if (m_pop) e = mq.pop_front();
            if (m_ack) mq.push_back(m_new);
            if (m_pop) starve = 0;
            else if (m_nonempty && !m_granted && starve < LIMIT) starve++;
        end
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle();
        sif.store_en          = 1'b0;
        sif.store_addr        = 32'h0;
        sif.store_data        = 32'h0;
        sif.is_32_bit         = 1'b0;
        sif.is_16_bit         = 1'b0;
        sif.load_mem_req      = 1'b0;
        sif.load_query_valid  = 1'b0;
        sif.load_query_addr   = 32'h0;
        sif.mem2proc_response = 4'h0;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input int sz);
        sif.store_en   = 1'b1;
        sif.store_addr = a;
        sif.store_data = d;
        sif.is_32_bit  = (sz == 2);
        sif.is_16_bit  = (sz == 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        settle();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        logic req_active;
        idle();
        do_reset();

        // Reset state.
        settle();
        check("rst_empty", sif.wb_empty, 1'b1);
        check("rst_cmd", sif.proc2mem_command, BUS_NONE);
        check("rst_hold", sif.store_mem_hold, 1'b0);
        check("rst_ack", sif.store_accepted, 1'b0);
        check("rst_conflict", sif.load_conflict, 1'b0);
        check("rst_addr", sif.proc2mem_addr, 32'h0);
        check("rst_data", sif.proc2mem_data, 64'h0);
        check("rst_size", sif.proc2mem_size, BYTE);
        advance();

        // SW 0x100: ack same cycle, BUS_STORE the next.
        set_store(32'h100, 32'hDEAD_BEEF, 2);
        sif.mem2proc_response = 4'h1;
        settle(); check("sw_ack", sif.store_accepted, 1'b1); advance();
        idle(); sif.mem2proc_response = 4'h1;
        settle();
        check("sw_cmd", sif.proc2mem_command, BUS_STORE);
        check("sw_addr", sif.proc2mem_addr, 32'h100);
        check("sw_data", sif.proc2mem_data, 64'hDEAD_BEEF);
        check("sw_size", sif.proc2mem_size, WORD);
        advance();

        // SB 0x103 and SH 0x102 right alignment.
        set_store(32'h103, 32'hAB00_0000, 0); sif.mem2proc_response = 4'h1;
        tick();
        idle(); sif.mem2proc_response = 4'h1;
        settle(); check("sb_data", sif.proc2mem_data, 64'hAB); check("sb_size", sif.proc2mem_size, BYTE); advance();
        set_store(32'h102, 32'h1234_0000, 1); sif.mem2proc_response = 4'h1;
        tick();
        idle(); sif.mem2proc_response = 4'h1;
        settle(); check("sh_data", sif.proc2mem_data, 64'h1234); check("sh_size", sif.proc2mem_size, HALF); advance();

        // Fill with no memory response; fifth store waits for a pop.
        for (int i = 0; i < 4; i++) begin
            set_store(32'h300 + 32'(4 * i), $urandom, 2); sif.mem2proc_response = 4'h0;
            settle(); check("fill_ack", sif.store_accepted, 1'b1); advance();
        end
        set_store(32'h340, 32'h5555_AAAA, 2);
        for (int i = 0; i < 3; i++) begin
            settle(); check("full_ack", sif.store_accepted, 1'b0); advance();
        end
        sif.mem2proc_response = 4'h3;
        tick();
        sif.mem2proc_response = 4'h0;
        settle(); check("after_pop_ack", sif.store_accepted, 1'b1); advance();
        idle(); sif.mem2proc_response = 4'h1;
        for (int i = 0; i < 6; i++) tick();
        settle(); check("drained", sif.wb_empty, 1'b1); advance();

        // Starvation: load port holds the bus, store waits exactly LIMIT cycles.
        set_store(32'h400, 32'h0BAD_F00D, 2); sif.mem2proc_response = 4'h1;
        tick();
        idle(); sif.load_mem_req = 1'b1; sif.mem2proc_response = 4'h1;
        for (int k = 0; k < 8; k++) begin
            settle(); check("starve_hold", sif.store_mem_hold, 1'b0); advance();
        end
        settle();
        check("starve_grant", sif.store_mem_hold, 1'b1);
        check("starve_cmd", sif.proc2mem_command, BUS_STORE);
        advance();
        idle();

        // Load conflict at 8-byte granularity.
        set_store(32'h200, 32'h1122_3344, 2); sif.mem2proc_response = 4'h0;
        sif.load_query_valid = 1'b1; sif.load_query_addr = 32'h204;
        settle(); check("conf_accepting", sif.load_conflict, 1'b1); advance();
        idle(); sif.load_query_valid = 1'b1; sif.load_query_addr = 32'h204;
        settle(); check("conf_204", sif.load_conflict, 1'b1); advance();
        sif.load_query_addr = 32'h208;
        settle(); check("conf_208", sif.load_conflict, 1'b0); advance();
        sif.load_query_valid = 1'b0; sif.mem2proc_response = 4'h1;
        tick();
        sif.mem2proc_response = 4'h0; sif.load_query_valid = 1'b1; sif.load_query_addr = 32'h204;
        settle(); check("conf_drained", sif.load_conflict, 1'b0); advance();
        idle();

        // Reset while draining three entries.
        for (int i = 0; i < 3; i++) begin
            set_store(32'h500 + 32'(4 * i), $urandom, 2); sif.mem2proc_response = 4'h0;
            tick();
        end
        idle();
        tick();
        do_reset();
        sif.mem2proc_response = 4'h1;
        settle();
        check("mid_rst_empty", sif.wb_empty, 1'b1);
        check("mid_rst_cmd", sif.proc2mem_command, BUS_NONE);
        advance();
        for (int i = 0; i < 3; i++) begin
            settle(); check("mid_rst_quiet", sif.proc2mem_command, BUS_NONE); advance();
        end

        // Randomized traffic; the SQ holds each request until it is acked.
        idle();
        req_active = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!req_active) begin
                if ($urandom_range(0, 99) < 60) begin
                    set_store(32'h100 + 32'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)));
                    req_active = 1'b1;
                end else begin
                    sif.store_en = 1'b0;
                end
            end
            if ((c % 100) < 40) sif.load_mem_req = ($urandom_range(0, 99) < 90);
            else                sif.load_mem_req = ($urandom_range(0, 99) < 30);
            sif.mem2proc_response = ($urandom_range(0, 99) < 60) ? 4'($urandom_range(1, 15)) : 4'h0;
            sif.load_query_valid  = ($urandom_range(0, 1) == 1);
            sif.load_query_addr   = 32'h100 + 32'($urandom_range(0, 63));
            settle();
            if (m_ack) req_active = 1'b0;
            advance();
        end
        idle(); sif.mem2proc_response = 4'h1;
        for (int i = 0; i < 10; i++) tick();
        settle(); check("final_empty", sif.wb_empty, 1'b1); advance();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
